// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port round-robin arbiter with bounded bursts for a
//             single-port data memory; routes read responses to their owner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(BURST_LEN);

    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
    logic             rsp_pending_q, rsp_pending_d;
    logic             rsp_owner_q,  rsp_owner_d;

    logic w_v0, w_v1, w_gnt_any, w_gnt_port, w_gnt_write;

    // Requests are masked while in reset so the memory sees no enables.
    assign w_v0      = req0_valid & rst_n;
    assign w_v1      = req1_valid & rst_n;
    assign w_gnt_any = w_v0 | w_v1;

    // A zero burst count only exists straight after reset; treating it as
    // "no burst in progress" hands the first contested grant to port 0.
    always_comb begin
        w_gnt_port = 1'b0;
        if (w_v0 && w_v1) begin
            if ((burst_cnt_q != '0) && (burst_cnt_q < C_BURST_MAX)) begin
                w_gnt_port = last_grant_q;
            end else begin
                w_gnt_port = ~last_grant_q;
            end
        end else if (w_v1) begin
            w_gnt_port = 1'b1;
        end
    end

    assign w_gnt_write = w_gnt_port ? req1_write : req0_write;

    assign req0_ready       = w_gnt_any & ~w_gnt_port;
    assign req1_ready       = w_gnt_any &  w_gnt_port;
    assign mem_write_enable = w_gnt_any &  w_gnt_write;
    assign mem_read_enable  = w_gnt_any & ~w_gnt_write;
    assign mem_address      = w_gnt_port ? req1_addr  : req0_addr;
    assign mem_write_data   = w_gnt_port ? req1_wdata : req0_wdata;

    always_comb begin
        last_grant_d  = last_grant_q;
        burst_cnt_d   = burst_cnt_q;
        rsp_pending_d = 1'b0;
        rsp_owner_d   = rsp_owner_q;
        if (w_gnt_any) begin
            if (w_gnt_port == last_grant_q) begin
                if (burst_cnt_q < C_BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                burst_cnt_d  = CNT_W'(1);
                last_grant_d = w_gnt_port;
            end
            if (!w_gnt_write) begin
                rsp_pending_d = 1'b1;
                rsp_owner_d   = w_gnt_port;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            burst_cnt_q   <= '0;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            burst_cnt_q   <= burst_cnt_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
        end
    end

    assign rsp0_valid = rsp_pending_q & ~rsp_owner_q;
    assign rsp1_valid = rsp_pending_q &  rsp_owner_q;
    assign rsp0_rdata = rsp0_valid ? mem_read_data : '0;
    assign rsp1_rdata = rsp1_valid ? mem_read_data : '0;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory (10-bit word address, 32-bit data, registered read, one-cycle read latency).
- Port 0 is the CPU load/store stage; port 1 is the debug/DMA loader.
- Grants at most one access per cycle using round-robin with a bounded burst, then drives the memory enables, address and write data.
- Routes the read data back to the requester that issued the read, with a response strobe.

Parameters:
- ADDR_W, 10, word-address width; matches memory depth of 1024.
- DATA_W, 32, data width.
- BURST_LEN, 4, max consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request present.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle (combinational).
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_write_enable  out  1  to memory write enable.
- mem_read_enable  out  1  to memory read enable.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write data.
- mem_read_data  in  DATA_W  from memory registered read data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - last_grant = 1, so port 0 has first priority.
  - burst_cnt = 0.
  - rsp_pending = 0, rsp_owner = 0.
  - Resulting outputs: rsp0_valid = rsp1_valid = 0. Memory enables are 0 because all req*_valid are ignored while rst_n is low.
- A transfer occurs on a rising edge where reqN_valid && reqN_ready.
- Requesters hold valid, write, addr and wdata stable until ready is seen.
- Grant decision, combinational from current state:
  - Only one port valid: grant it.
  - Both valid, last_grant = g, and burst_cnt < BURST_LEN: grant g (burst continues).
  - Both valid and burst_cnt >= BURST_LEN: grant the other port.
  - Exactly one reqN_ready is high in any cycle; neither is high when no request is present.
- State update on each transfer to port p:
  - If p == last_grant, burst_cnt = burst_cnt + 1, saturating at BURST_LEN.
  - Otherwise burst_cnt = 1 and last_grant = p.
  - A cycle with no transfer leaves burst_cnt and last_grant unchanged. An idle gap therefore does not reset fairness.
- Memory drive in the granted cycle:
  - mem_address and mem_write_data are muxed from the granted port.
  - mem_write_enable = granted write.
  - mem_read_enable = granted read.
  - With no grant both enables are 0; address and data hold the port 0 values (don't care).
- Read response:
  - When a read is accepted, rsp_pending = 1 and rsp_owner = p on that edge.
  - In the next cycle rspP_valid = 1 and rspP_rdata = mem_read_data. Latency is exactly 1 cycle after acceptance.
  - The non-owner's rsp_valid is 0 and its rsp_rdata is 0.
  - Back-to-back reads: each read gets its own response cycle, in grant order, because the single pending register is overwritten every cycle.
  - Writes produce no response.
- A write followed by a read of the same address in the next cycle returns the new data (memory write commits on the first edge).
- Reset mid-operation: a pending response is dropped; no rsp_valid follows reset release.

Test Plan:
- Reset, then port 0 writes 87 to addr 10, then reads addr 10 -> rsp0_valid high exactly 1 cycle after the read grant, rsp0_rdata = 87, rsp1_valid stays 0.
- Port 1 writes 96 to addr 20 and 33 to addr 21, then reads 21 while port 0 idle -> rsp1_rdata = 33, no rsp0_valid.
- Both ports hold valid reads continuously with BURST_LEN = 4 -> grant sequence 0,0,0,0,1,1,1,1,0,... with one ready per cycle and responses routed to the matching port.
- Simultaneous first request after reset -> port 0 granted first. Port 0 drops after 2 grants, port 1 requests, port 0 re-requests -> port 1 holds until its 4th grant.
- Port 0 write addr 1000 = 48 in cycle n, port 1 read addr 1000 in cycle n+1 -> rsp1_rdata = 48 in cycle n+2.
- rst_n pulsed low in the cycle after a read grant -> no rsp_valid after release; the next simultaneous request grants port 0.
